// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, controller states and preload constant for the data memory.
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam logic [31:0] PRELOAD_WORD = 32'h00000FFF;
  typedef enum logic [1:0] {INIT, PRELOAD, RUN} state_t;
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: picks the addressed byte/half out of a word and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    data = size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
           size == SZ_HALF ? {{16{~uns & h[15]}}, h} : word;
  end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: byte-addressed data memory with hardware clear, registered loads and error pulses.
// Define DMEM_PRELOAD_EN to write PRELOAD_WORD into words 0 and 1 after the clear.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [31:0]       write_data,
  output logic              ready,
  output logic [31:0]       read_data,
  output logic              read_valid,
  output logic              err
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];
  state_t state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic [31:0] read_data_q, read_data_d;
  logic read_valid_q, read_valid_d, err_q, err_d;
  logic req, bad, misal, oor;
  logic [IDX_W-1:0] idx;
  logic [1:0] lane;
  logic [31:0] ld_ext;
  logic wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0] wr_data;
  logic [3:0] wr_be;

  assign ready      = state_q == RUN;
  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign err        = err_q;

  dmem_load_align u_align (
    .word (mem[idx]),
    .lane (lane),
    .size (mem_size),
    .uns  (mem_unsigned),
    .data (ld_ext)
  );

  always_comb begin
    idx   = endereco[IDX_W+1:2];
    lane  = endereco[1:0];
    req   = ready && (mem_read || mem_write);
    misal = (mem_size == SZ_HALF && endereco[0]) || (mem_size == SZ_WORD && endereco[1:0] != 2'b00);
    // Widened compare so addresses past the array never alias back into it.
    oor   = {1'b0, endereco} >= (ADDR_W+1)'(4 * DEPTH);
    bad   = (mem_read && mem_write) || mem_size == SZ_ILL || misal || oor;
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_en     = 1'b0;
    wr_idx    = idx;
    wr_data   = '0;
    wr_be     = 4'b1111;
    case (state_q)
      INIT: begin
        wr_en     = 1'b1;
        wr_idx    = clr_idx_q;
        clr_idx_d = clr_idx_q + IDX_W'(1);
`ifdef DMEM_PRELOAD_EN
        if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = PRELOAD;
`else
        if (clr_idx_q == IDX_W'(DEPTH - 1)) state_d = RUN;
`endif
      end
`ifdef DMEM_PRELOAD_EN
      PRELOAD: begin
        wr_en     = 1'b1;
        wr_idx    = clr_idx_q;
        wr_data   = PRELOAD_WORD;
        clr_idx_d = clr_idx_q + IDX_W'(1);
        if (clr_idx_q == IDX_W'(1)) state_d = RUN;
      end
`endif
      default: begin
        wr_en   = req && !bad && mem_write;
        wr_data = mem_size == SZ_BYTE ? {4{write_data[7:0]}} :
                  mem_size == SZ_HALF ? {2{write_data[15:0]}} : write_data;
        wr_be   = mem_size == SZ_BYTE ? 4'b0001 << lane :
                  mem_size == SZ_HALF ? (endereco[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      end
    endcase
    read_valid_d = req && !bad && mem_read;
    err_d        = req && bad;
    read_data_d  = read_valid_d ? ld_ext : read_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      clr_idx_q    <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (wr_en && wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
  end
endmodule
